multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 137 +++++++++++++
 tb/tb_multicycle_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: five-state fetch/decode/execute/memory/writeback control FSM with a sticky trap state.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit EN_UTYPE    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             jal_signal,
    output logic [1:0]       ALUOp,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_count
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam int         WW       = $clog2(MEM_TIMEOUT + 2);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q;
    logic             legal, timed_out, is_jump;

    assign legal = (Opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR}) ||
                   (EN_UTYPE && (Opcode inside {OP_LUI, OP_AUIPC}));
    assign timed_out = (MEM_TIMEOUT > 0) && (wait_q == WW'(MEM_TIMEOUT));
    assign is_jump = (op_q == OP_JAL) || (op_q == OP_JALR);
    assign state = state_q;
    assign retire_count = cnt_q;

    // Next-state, wait counting and Moore control decode; everything is forced low while reset is held.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = wait_q;
        imem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        jal_signal = 1'b0;
        ALUOp      = 2'b00;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                IRWrite  = imem_ready;
                state_d  = imem_ready ? DECODE : (timed_out ? TRAP : FETCH);
                wait_d   = imem_ready ? wait_q : wait_q + 1'b1;
            end
            DECODE: begin
                op_d    = Opcode;
                state_d = legal ? EXEC : TRAP;
            end
            EXEC: begin
                ALUSrc  = op_q inside {OP_LW, OP_SW, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
                ALUOp   = (op_q == OP_BR) ? 2'b01 :
                          (op_q == OP_R || op_q == OP_I) ? 2'b10 :
                          is_jump ? 2'b11 : 2'b00;
                Branch  = op_q == OP_BR;
                PCWrite = op_q == OP_BR;
                state_d = (op_q == OP_BR) ? FETCH :
                          (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
            end
            MEM: begin
                MemRead  = op_q == OP_LW;
                MemWrite = op_q == OP_SW;
                PCWrite  = dmem_ready && (op_q == OP_SW);
                state_d  = dmem_ready ? ((op_q == OP_SW) ? FETCH : WB) : (timed_out ? TRAP : MEM);
                wait_d   = dmem_ready ? wait_q : wait_q + 1'b1;
            end
            WB: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                MemtoReg   = op_q == OP_LW;
                Branch     = is_jump;
                jal_signal = is_jump;
                state_d    = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_d = FETCH;
        endcase
        if (state_d != state_q) wait_d = '0;
        if (reset) begin
            {imem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite} = '0;
            {MemRead, MemWrite, Branch, jal_signal, ALUOp, trap} = '0;
        end
    end

    // State, latched opcode, wait counter and retire counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_q + CNT_W'(PCWrite);
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle control FSM with hand-computed control vectors.
module tb_multicycle_controller;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset, imem_ready, dmem_ready;
    logic [6:0]  Opcode;
    logic        imem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jal_signal, trap;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic [3:0]  retire_count;
    logic        imem_req2, IRWrite2, PCWrite2, ALUSrc2, MemtoReg2, RegWrite2, MemRead2, MemWrite2, Branch2, jal_signal2, trap2;
    logic [1:0]  ALUOp2;
    logic [2:0]  state2;
    logic [31:0] retire_count2;
    logic [12:0] ctl, ctl2;
    logic [3:0]  exp_ret;
    int          n_chk = 0;
    int          n_pass = 0;

    assign ctl  = {imem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jal_signal, ALUOp, trap};
    assign ctl2 = {imem_req2, IRWrite2, PCWrite2, ALUSrc2, MemtoReg2, RegWrite2, MemRead2, MemWrite2, Branch2, jal_signal2, ALUOp2, trap2};

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4), .EN_UTYPE(1'b0)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .jal_signal(jal_signal),
        .ALUOp(ALUOp), .trap(trap), .state(state), .retire_count(retire_count)
    );

    multicycle_controller u_dut2 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req2), .IRWrite(IRWrite2), .PCWrite(PCWrite2), .ALUSrc(ALUSrc2), .MemtoReg(MemtoReg2),
        .RegWrite(RegWrite2), .MemRead(MemRead2), .MemWrite(MemWrite2), .Branch(Branch2), .jal_signal(jal_signal2),
        .ALUOp(ALUOp2), .trap(trap2), .state(state2), .retire_count(retire_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] c);
        #1;
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_ctl"}, 32'(ctl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic fd(input logic [6:0] op);
        imem_ready = 1'b1;
        Opcode = op;
        cyc("fetch", 3'd0, 13'h1800);
        imem_ready = 1'b0;
        cyc("decode", 3'd1, 13'h000);
    endtask

    task automatic ret_chk(input string tag);
        exp_ret++;
        chk(tag, 32'(retire_count), 32'(exp_ret));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_ret", 32'(retire_count), 32'd0);
        exp_ret = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        Opcode = '0;
        exp_ret = '0;
        #3;
        chk("init_state", 32'(state), 32'd0);
        chk("init_ctl", 32'(ctl), 32'd0);
        chk("init_ret", 32'(retire_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fd(OP_R);
        cyc("r_ex", 3'd2, 13'h004);
        cyc("r_wb", 3'd4, 13'h480);
        ret_chk("r_ret");
        imem_ready = 1'b0;
        cyc("lw_wait", 3'd0, 13'h1000);
        fd(OP_LW);
        cyc("lw_ex", 3'd2, 13'h200);
        for (int i = 0; i < 2; i++) cyc("lw_mem", 3'd3, 13'h040);
        dmem_ready = 1'b1;
        cyc("lw_mem_rdy", 3'd3, 13'h040);
        dmem_ready = 1'b0;
        cyc("lw_wb", 3'd4, 13'h580);
        ret_chk("lw_ret");
        fd(OP_SW);
        cyc("sw_ex", 3'd2, 13'h200);
        cyc("sw_mem", 3'd3, 13'h020);
        dmem_ready = 1'b1;
        cyc("sw_mem_rdy", 3'd3, 13'h420);
        dmem_ready = 1'b0;
        ret_chk("sw_ret");
        fd(OP_BR);
        cyc("br_ex", 3'd2, 13'h412);
        ret_chk("br_ret");
        chk("br_skip", 32'(state), 32'd0);
        fd(OP_JAL);
        cyc("jal_ex", 3'd2, 13'h206);
        cyc("jal_wb", 3'd4, 13'h498);
        ret_chk("jal_ret");
        fd(OP_JALR);
        cyc("jalr_ex", 3'd2, 13'h206);
        cyc("jalr_wb", 3'd4, 13'h498);
        ret_chk("jalr_ret");
        fd(OP_I);
        cyc("i_ex", 3'd2, 13'h204);
        cyc("i_wb", 3'd4, 13'h480);
        ret_chk("i_ret");
        fd(OP_LW);
        cyc("lw4_ex", 3'd2, 13'h200);
        for (int i = 0; i < 3; i++) cyc("lw4_mem", 3'd3, 13'h040);
        dmem_ready = 1'b1;
        cyc("lw4_mem_rdy", 3'd3, 13'h040);
        dmem_ready = 1'b0;
        cyc("lw4_wb", 3'd4, 13'h580);
        ret_chk("lw4_ret");
        fd(OP_SW);
        cyc("sw5_ex", 3'd2, 13'h200);
        for (int i = 0; i < 4; i++) cyc("sw5_mem", 3'd3, 13'h020);
        dmem_ready = 1'b1;
        cyc("sw5_mem_rdy", 3'd3, 13'h420);
        dmem_ready = 1'b0;
        ret_chk("sw5_ret");
        fd(OP_LW);
        cyc("to_ex", 3'd2, 13'h200);
        for (int i = 0; i < 5; i++) cyc("to_mem", 3'd3, 13'h040);
        for (int i = 0; i < 20; i++) cyc("to_trap", 3'd5, 13'h001);
        chk("to_ret", 32'(retire_count), 32'(exp_ret));
        pulse_reset();
        fd(OP_SW);
        cyc("mr_ex", 3'd2, 13'h200);
        cyc("mr_mem", 3'd3, 13'h020);
        reset = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_ctl", 32'(ctl), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dmem_ready = 1'b0;
        cyc("mr_fetch", 3'd0, 13'h1000);
        chk("mr_ret", 32'(retire_count), 32'd0);
        fd(7'b0000000);
        for (int i = 0; i < 20; i++) cyc("ill_trap", 3'd5, 13'h001);
        pulse_reset();
        fd(OP_LUI);
        #1;
        chk("lui_state", 32'(state), 32'd5);
        chk("lui_ctl", 32'(ctl), 32'h001);
        chk("lui2_ex_state", 32'(state2), 32'd2);
        chk("lui2_ex_ctl", 32'(ctl2), 32'h200);
        @(posedge clk);
        #1;
        chk("lui2_wb_state", 32'(state2), 32'd4);
        chk("lui2_wb_ctl", 32'(ctl2), 32'h480);
        @(posedge clk);
        #1;
        chk("lui2_ret", retire_count2, 32'd1);
        chk("lui_trap_ret", 32'(retire_count), 32'd0);
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            fd(OP_BR);
            cyc("wrap_ex", 3'd2, 13'h412);
            ret_chk("wrap_ret");
        end
        chk("wrap_zero", 32'(retire_count), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
